mdu_hilo: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers for the five-stage MIPS core. It sits beside the ALU in the Execute stage. The Execute stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to it, and the Decode-stage hazard logic consumes `start | busy` to stall MD-class instructions. The unit models fixed hardware latency: the result is computed at issue and committed to HI/LO only after the latency counter expires.

---
 rtl/mdu_hilo.sv | 133 +++++++++++++
 tb/tb_mdu_hilo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multi-cycle multiply/divide unit with architectural HI/LO
// Optional MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] hi_p, lo_p, hi_p_n, lo_p_n, hi_n, lo_n;

    logic        commit, can_issue, is_mul, is_div;
    logic [31:0] cur_hi, cur_lo;
    logic [63:0] a_sx, b_sx, prod_s, prod_u, mul_res;
    logic [31:0] b_safe, q_s, r_s, q_u, r_u, div_q, div_r;
    logic        b_nz, div_ovf;

    // The completion edge can also accept a new op, which must see the committed values.
    assign commit    = (state == RUN) && (cnt == 4'd0);
    assign can_issue = start && ((state == IDLE) || commit);
    assign cur_hi    = commit ? hi_p : hi;
    assign cur_lo    = commit ? lo_p : lo;

`ifdef MDU_MADD_EN
    assign is_mul = (op == 4'd1) || (op == 4'd2) || ((op >= 4'd7) && (op <= 4'd10));
`else
    assign is_mul = (op == 4'd1) || (op == 4'd2);
`endif
    assign is_div = (op == 4'd3) || (op == 4'd4);

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    always_comb begin
        mul_res = prod_s;
        case (op)
            4'd2:    mul_res = prod_u;
`ifdef MDU_MADD_EN
            4'd7:    mul_res = {cur_hi, cur_lo} + prod_s;
            4'd8:    mul_res = {cur_hi, cur_lo} + prod_u;
            4'd9:    mul_res = {cur_hi, cur_lo} - prod_s;
            4'd10:   mul_res = {cur_hi, cur_lo} - prod_u;
`endif
            default: mul_res = prod_s;
        endcase
    end

    // Divisor forced non-zero so the dividers never see 0; the b==0 result is discarded.
    assign b_nz    = (b != 32'd0);
    assign b_safe  = b_nz ? b : 32'd1;
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign q_s     = $signed(a) / $signed(b_safe);
    assign r_s     = $signed(a) % $signed(b_safe);
    assign q_u     = a / b_safe;
    assign r_u     = a % b_safe;
    assign div_q   = (op == 4'd3) ? (div_ovf ? 32'h8000_0000 : q_s) : q_u;
    assign div_r   = (op == 4'd3) ? (div_ovf ? 32'd0 : r_s) : r_u;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_p_n  = hi_p;
        lo_p_n  = lo_p;
        hi_n    = hi;
        lo_n    = lo;
        if (state == RUN) begin
            if (commit) begin
                hi_n    = hi_p;
                lo_n    = lo_p;
                state_n = IDLE;
            end else begin
                cnt_n = cnt - 4'd1;
            end
        end
        if (can_issue) begin
            if (is_mul) begin
                {hi_p_n, lo_p_n} = mul_res;
                cnt_n            = MULT_LOAD;
                state_n          = RUN;
            end else if (is_div) begin
                if (b_nz) begin
                    hi_p_n = div_r;
                    lo_p_n = div_q;
                end else begin
                    hi_p_n = cur_hi;
                    lo_p_n = cur_lo;
                end
                cnt_n   = DIV_LOAD;
                state_n = RUN;
            end else if (op == 4'd5) begin
                hi_n = a;
            end else if (op == 4'd6) begin
                lo_n = a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            hi_p  <= 32'd0;
            lo_p  <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi_p  <= hi_p_n;
            lo_p  <= lo_p_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    assign busy = (state == RUN);
endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - scoreboard testbench for mdu_hilo
// Expected per-cycle busy/HI/LO are queued at issue time and checked by a monitor.
module tb_mdu_hilo;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, busy;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          busy;
        logic [31:0] hi;
        logic [31:0] lo;
        int          tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          tag = 0;
    logic [31:0] hi_m, lo_m;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input bit bz, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.cyc = c; e.busy = bz; e.hi = h; e.lo = l; e.tag = tag;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc || busy !== e.busy || hi !== e.hi || lo !== e.lo) begin
                failures = failures + 1;
                $display("FAIL op%0d cyc=%0d busy=%b hi=%h lo=%h required busy=%b hi=%h lo=%h",
                         e.tag, cyc, busy, hi, lo, e.busy, e.hi, e.lo);
            end
        end
    end

    // Reference model: architectural effect and latency of one issued op.
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        int                ix, iy;
        longint            ps;
        longint unsigned   ux, uy, pu;
        logic [63:0]       acc;
        ix = x; iy = y; ux = x; uy = y;
        ps = longint'(ix) * longint'(iy);
        pu = ux * uy;
        acc = {hi_m, lo_m};
        lat = 0;
        case (o)
            4'd1: begin {hi_m, lo_m} = ps; lat = MC; end
            4'd2: begin {hi_m, lo_m} = pu; lat = MC; end
            4'd3: begin
                lat = DC;
                if (y == 0) begin
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    lo_m = 32'h8000_0000; hi_m = 32'd0;
                end else begin
                    lo_m = ix / iy; hi_m = ix % iy;
                end
            end
            4'd4: begin
                lat = DC;
                if (y != 0) begin lo_m = x / y; hi_m = x % y; end
            end
            4'd5: hi_m = x;
            4'd6: lo_m = x;
`ifdef MDU_MADD_EN
            4'd7:  begin {hi_m, lo_m} = acc + ps; lat = MC; end
            4'd8:  begin {hi_m, lo_m} = acc + pu; lat = MC; end
            4'd9:  begin {hi_m, lo_m} = acc - ps; lat = MC; end
            4'd10: begin {hi_m, lo_m} = acc - pu; lat = MC; end
`endif
            default: ;
        endcase
    endtask

    // Called just after a rising edge. With chain set, returns in time to issue on the completion edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input bit chain);
        int          k, lat;
        logic [31:0] oh, ol;
        k = cyc; oh = hi_m; ol = lo_m;
        model(o, x, y, lat);
        op = o; a = x; b = y; start = 1'b1;
        if (lat == 0) begin
            push(k + 1, 1'b0, hi_m, lo_m);
        end else begin
            for (int i = 1; i <= lat; i++) push(k + i, 1'b1, oh, ol);
            if (!chain) push(k + lat + 1, 1'b0, hi_m, lo_m);
        end
        tag = tag + 1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); a = 32'($urandom); b = 32'($urandom);
        if (lat > 0) begin
            if (chain) repeat (lat - 1) @(posedge clk);
            else       repeat (lat) @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
        hi_m = 32'd0; lo_m = 32'd0;
        repeat (2) @(posedge clk); #1;
        push(cyc, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
        issue(4'd3, 32'd5, 32'd0, 1'b0);
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(4'd6, 32'd10, 32'd0, 1'b0);
        issue(4'd7, 32'd3, 32'd4, 1'b0);
        issue(4'd0, 32'd1, 32'd1, 1'b0);
        issue(4'd15, 32'd1, 32'd1, 1'b0);

        // Reset lands on the third busy cycle of a divide; nothing may commit afterwards.
        k = cyc;
        op = 4'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        push(k + 1, 1'b1, hi_m, lo_m);
        push(k + 2, 1'b1, hi_m, lo_m);
        tag = tag + 1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        for (int i = 0; i < 14; i++) push(k + 3 + i, 1'b0, 32'd0, 32'd0);
        repeat (14) @(posedge clk); #1;

        for (int i = 0; i < 80; i++) begin
            issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), (i < 79) && ($urandom_range(0, 2) == 0));
        end

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk); #1;
        if (sb.size() > 0) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL drain pending=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL watchdog cyc=%0d required finish before timeout", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
